// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: the instruction-memory read port and the decode
// valid/ready port. The fetch queue drives the master side.
interface fetch_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output mem_req, mem_addr, out_valid, out_instr, out_pc,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_instr, out_pc,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Sequential-PC instruction fetcher with a DEPTH-entry {instr, pc} FIFO towards decode.
// Optional FETCH_QUEUE_PERF_CNT_EN adds saturating stall/flush performance counters.
module fetch_queue #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    fetch_queue_if.master              bus,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_QUEUE_PERF_CNT_EN
    ,
    output logic [31:0]                perf_stall_cycles,
    output logic [15:0]                perf_flush_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    entry_t            head_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              issue;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    logic [CNT_W:0]    credit_used;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic [PTR_W-1:0]  rd_ptr_next;

    // Credit is computed from registered state only, so a pop this cycle
    // frees a slot for fetch only from the next cycle on.
    always_comb begin
        credit_used   = {1'b0, cnt_q} + (CNT_W+1)'(inflight_q);
        issue         = !reset && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
        push          = inflight_q && !redirect && !reset;
        pop           = bus.out_valid && bus.out_ready;
        push_entry    = '{instr: bus.mem_rdata, pc: inflight_pc_q};
        cnt_after_pop = cnt_q - CNT_W'(pop);
        rd_ptr_next   = rd_ptr_q + PTR_W'(pop);
    end

    assign bus.mem_req   = issue;
    assign bus.mem_addr  = pc_q;
    assign bus.out_valid = !reset && (cnt_q != '0);
    assign bus.out_instr = reset ? '0 : head_q.instr;
    assign bus.out_pc    = reset ? '0 : head_q.pc;
    assign count         = reset ? '0 : cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            head_q        <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + ADDR_W'(PC_STEP);
            end
            if (redirect) begin
                // issue is low here, so this is the only pc update this cycle.
                pc_q     <= redirect_pc;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                rd_ptr_q <= rd_ptr_next;
                cnt_q    <= cnt_after_pop + CNT_W'(push);
                // The head register holds the next head entry, or keeps its last
                // value when the queue drains, giving stable decode-side outputs.
                if (push && (cnt_after_pop == '0)) begin
                    head_q <= push_entry;
                end else if (cnt_after_pop != '0) begin
                    head_q <= fifo_q[rd_ptr_next];
                end
            end
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone decide
    // which entries are meaningful, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

`ifdef FETCH_QUEUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (redirect && (perf_flush_count != '1)) begin
                perf_flush_count <= perf_flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
